core_io_peripheral: RTL

- Peripheral-side endpoint of the core's `to_peripheral` / `from_peripheral` result/I-O interface.
- Inbound: captures every single-cycle result report pulsed by the core. The core gives no backpressure, so reports go into a FIFO that a host-side valid/ready consumer drains.
- Outbound: accepts host commands over valid/ready and issues each one to the core as a one-cycle `from_peripheral_valid` pulse, with a programmable minimum gap between pulses.
- Sits beside each core instance at the top level; keeps result and overflow counts for performance reporting.

---
 rtl/core_io_peripheral.sv | 135 +++++++++++++
 1 files changed

// File: rtl/core_io_peripheral.sv
// Peripheral-side endpoint of the core result/I-O interface: an inbound report FIFO
// drained by the host, and a paced outbound command path with status counters.
module core_io_peripheral #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_ADDR_BITS = 3,
  parameter int MIN_GAP        = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [1:0]                to_peripheral,
  input  logic [DATA_WIDTH-1:0]     to_peripheral_data,
  input  logic                      to_peripheral_valid,
  output logic [1:0]                from_peripheral,
  output logic [DATA_WIDTH-1:0]     from_peripheral_data,
  output logic                      from_peripheral_valid,
  output logic [1:0]                host_rx_code,
  output logic [DATA_WIDTH-1:0]     host_rx_data,
  output logic                      host_rx_valid,
  input  logic                      host_rx_ready,
  input  logic [1:0]                host_tx_code,
  input  logic [DATA_WIDTH-1:0]     host_tx_data,
  input  logic                      host_tx_valid,
  output logic                      host_tx_ready,
  output logic [FIFO_ADDR_BITS:0]   fifo_level,
  output logic [CNT_WIDTH-1:0]      result_count,
  output logic [CNT_WIDTH-1:0]      overflow_count
);

  // Host handshakes: a transfer happens on a rising clock edge where valid & ready
  // are both 1; valid never waits on ready, and a held payload is stable until taken.

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [GAP_W-1:0]        GAP_LOAD = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
  localparam logic [FIFO_ADDR_BITS:0] DEPTH_L  = (FIFO_ADDR_BITS + 1)'(DEPTH);

  // ---------------- inbound FIFO ----------------
  logic [DATA_WIDTH+1:0]     mem [DEPTH];
  logic [FIFO_ADDR_BITS-1:0] wr_ptr;
  logic [FIFO_ADDR_BITS-1:0] rd_ptr;
  logic                      full;
  logic                      pop;
  logic                      push_ok;
  logic                      drop;

  assign full          = (fifo_level == DEPTH_L);
  assign host_rx_valid = (fifo_level != '0);
  assign pop           = host_rx_valid & host_rx_ready;
  // A full FIFO still accepts a report when the head leaves in the same cycle.
  assign push_ok       = to_peripheral_valid & (~full | pop);
  assign drop          = to_peripheral_valid & ~push_ok;
  assign {host_rx_code, host_rx_data} = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= {to_peripheral, to_peripheral_data};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      result_count   <= '0;
      overflow_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (push_ok && result_count != '1)  result_count   <= result_count + 1'b1;
      if (drop && overflow_count != '1)   overflow_count <= overflow_count + 1'b1;
    end
  end

  // ---------------- outbound command FSM ----------------
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  tx_state_t        state;
  tx_state_t        state_next;
  logic [GAP_W-1:0] gap_cnt;
  logic             tx_idle;
  logic             accept;
  logic             fire;

  always_comb begin
    state_next = state;
    tx_idle    = 1'b0;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        tx_idle = 1'b1;
        if (host_tx_valid) state_next = SEND;
      end
      SEND: begin
        fire       = 1'b1;
        state_next = (MIN_GAP > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready is forced low while reset is held, even though the state sits at IDLE.
  assign host_tx_ready         = tx_idle & reset;
  assign accept                = host_tx_ready & host_tx_valid;
  assign from_peripheral_valid = fire;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      gap_cnt              <= '0;
      from_peripheral      <= '0;
      from_peripheral_data <= '0;
    end else begin
      state <= state_next;
      if (state == SEND)                      gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (accept) begin
        from_peripheral      <= host_tx_code;
        from_peripheral_data <= host_tx_data;
      end
    end
  end

endmodule
